hyperbus_responder: RTL and testbench

Synthesizable HyperBus target that acts as the device end of the HyperRAM link, answering the transactions issued by `hyper_xface`. It decodes the 48-bit command/address (CA) phase, applies a fixed initial latency, and serves linear read and write bursts from an internal 16-bit-wide memory plus a small register space (ID0, CR0). It is used as the loopback target in simulation and in FPGA self-test builds where no physical HyperRAM is fitted. All link pins are oversampled in the `clk` domain.

---
 rtl/hyperbus_pkg.sv | 26 ++
 rtl/hyperbus_if.sv | 22 ++
 rtl/hyperbus_mem.sv | 23 ++
 rtl/hyperbus_responder.sv | 195 +++++++++++++++++++
 tb/tb_hyperbus_responder.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/hyperbus_pkg.sv
// Shared definitions for the HyperBus responder: FSM states, CA field
// positions, register addresses and RWDS mask polarity.
package hyperbus_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCa,
        StLat,
        StWdata,
        StRdata,
        StRegw
    } state_t;

    // Bit positions inside the 48-bit command/address word
    localparam int unsigned CA_RW_BIT = 47;
    localparam int unsigned CA_AS_BIT = 46;
    localparam int unsigned CA_BT_BIT = 45;
    localparam int unsigned CA_BYTES  = 6;

    // Register space: word address 0 is ID0, anything else reads CR0
    localparam logic [31:0] REG_ID0_ADDR = 32'h0000_0000;

    // RWDS level that suppresses a write byte
    localparam logic RWDS_MASKED = 1'b1;

endpackage

// File: rtl/hyperbus_if.sv
// HyperBus link pins as seen between controller (master) and device (slave).
interface hyperbus_if;
    logic       dram_ck;
    logic       dram_cs_l;
    logic       dram_rst_l;
    logic [7:0] dram_dq_in;
    logic [7:0] dram_dq_out;
    logic       dram_dq_oe_l;
    logic       dram_rwds_in;
    logic       dram_rwds_out;
    logic       dram_rwds_oe_l;

    modport master (
        output dram_ck, dram_cs_l, dram_rst_l, dram_dq_in, dram_rwds_in,
        input  dram_dq_out, dram_dq_oe_l, dram_rwds_out, dram_rwds_oe_l
    );

    modport slave (
        input  dram_ck, dram_cs_l, dram_rst_l, dram_dq_in, dram_rwds_in,
        output dram_dq_out, dram_dq_oe_l, dram_rwds_out, dram_rwds_oe_l
    );
endinterface

// File: rtl/hyperbus_mem.sv
// 2^AW x 16 synchronous RAM: one registered read port, one write port with
// per-byte enables (we[1] = [15:8], we[0] = [7:0]). Contents have no reset.
module hyperbus_mem #(
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [1:0]    we
);

    logic [15:0] mem [2**AW];

    // Byte-masked write and registered read
    always_ff @(posedge clk) begin
        if (we[1]) mem[waddr][15:8] <= wdata[15:8];
        if (we[0]) mem[waddr][7:0]  <= wdata[7:0];
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/hyperbus_responder.sv
// HyperBus device model: decodes the CA phase, waits a fixed latency and
// serves linear bursts from an internal RAM or the ID0/CR0 registers.
module hyperbus_responder
    import hyperbus_pkg::*;
#(
    parameter int unsigned MEM_AW        = 10,
    parameter int unsigned LATENCY_EDGES = 22,
    parameter logic [15:0] ID0_VAL       = 16'h0C81,
    parameter logic [15:0] CR0_RST       = 16'h8F1F
) (
    input  logic        clk,
    input  logic        reset,
    hyperbus_if.slave   bus,
    output logic [15:0] cr0
);

    localparam int unsigned LAT_W = $clog2(LATENCY_EDGES + 1);

    state_t            state_q;
    logic              ck_q;
    logic              cs_q;
    logic [39:0]       ca_q;
    logic [2:0]        ca_cnt_q;
    logic [LAT_W-1:0]  lat_cnt_q;
    logic              odd_q;
    logic              rw_q;
    logic              reg_q;
    logic [MEM_AW-1:0] addr_q;
    logic [7:0]        reg_hi_q;
    logic [15:0]       cr0_q;
    logic [7:0]        dq_out_q;
    logic              dq_oe_l_q;
    logic              rwds_out_q;
    logic              rwds_oe_l_q;

    logic              ck_edge;
    logic              active;
    logic [47:0]       ca_next;
    logic [MEM_AW-1:0] addr_d;
    logic [1:0]        mem_we;
    logic [15:0]       mem_rdata;
    logic [15:0]       rd_word;
    logic              unused_ca;

    // Edge detect, next address (also the RAM read address, so the next word
    // is already fetched when the low byte goes out) and write enables
    always_comb begin
        ck_edge = bus.dram_ck != ck_q;
        active  = !bus.dram_cs_l && bus.dram_rst_l;
        ca_next = {ca_q, bus.dram_dq_in};
        addr_d  = addr_q;
        mem_we  = 2'b00;
        if (active && ck_edge) begin
            if (state_q == StCa && ca_cnt_q == 3'(CA_BYTES - 1)) begin
                addr_d = MEM_AW'({ca_next[44:16], ca_next[2:0]});
            end
            if ((state_q == StWdata || state_q == StRdata) && odd_q) begin
                addr_d = addr_q + 1'b1;
            end
            if (state_q == StWdata && bus.dram_rwds_in != RWDS_MASKED) begin
                mem_we = odd_q ? 2'b01 : 2'b10;
            end
        end
        if (reg_q) begin
            rd_word = (addr_q == MEM_AW'(REG_ID0_ADDR)) ? ID0_VAL : cr0_q;
        end else begin
            rd_word = mem_rdata;
        end
    end

    // Burst type and the unused middle CA bits play no part: all bursts are linear
    assign unused_ca = ^{ca_next[CA_BT_BIT], ca_next[15:3]};

    hyperbus_mem #(
        .AW(MEM_AW)
    ) u_mem (
        .clk   (clk),
        .raddr (addr_d),
        .rdata (mem_rdata),
        .waddr (addr_q),
        .wdata ({bus.dram_dq_in, bus.dram_dq_in}),
        .we    (mem_we)
    );

    // Link FSM with registered pin outputs; CS high or device reset aborts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            ck_q        <= 1'b0;
            cs_q        <= 1'b1;
            ca_q        <= '0;
            ca_cnt_q    <= '0;
            lat_cnt_q   <= '0;
            odd_q       <= 1'b0;
            rw_q        <= 1'b0;
            reg_q       <= 1'b0;
            addr_q      <= '0;
            reg_hi_q    <= '0;
            cr0_q       <= CR0_RST;
            dq_out_q    <= '0;
            dq_oe_l_q   <= 1'b1;
            rwds_out_q  <= 1'b0;
            rwds_oe_l_q <= 1'b1;
        end else begin
            ck_q   <= bus.dram_ck;
            cs_q   <= bus.dram_cs_l;
            addr_q <= addr_d;
            if (!bus.dram_rst_l || bus.dram_cs_l) begin
                state_q     <= StIdle;
                dq_out_q    <= '0;
                dq_oe_l_q   <= 1'b1;
                rwds_out_q  <= 1'b0;
                rwds_oe_l_q <= 1'b1;
                if (!bus.dram_rst_l) cr0_q <= CR0_RST;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        // Only a fresh CS fall starts a transaction
                        if (cs_q) begin
                            state_q     <= StCa;
                            ca_cnt_q    <= '0;
                            rwds_oe_l_q <= 1'b0;
                            rwds_out_q  <= 1'b1;
                        end
                    end
                    StCa: begin
                        if (ck_edge) begin
                            ca_q     <= ca_next[39:0];
                            ca_cnt_q <= ca_cnt_q + 3'd1;
                            if (ca_cnt_q == 3'(CA_BYTES - 1)) begin
                                rw_q        <= ca_next[CA_RW_BIT];
                                reg_q       <= ca_next[CA_AS_BIT];
                                odd_q       <= 1'b0;
                                lat_cnt_q   <= '0;
                                rwds_oe_l_q <= 1'b1;
                                rwds_out_q  <= 1'b0;
                                if (ca_next[CA_AS_BIT] && !ca_next[CA_RW_BIT]) begin
                                    state_q <= StRegw;
                                end else begin
                                    state_q <= StLat;
                                end
                            end
                        end
                    end
                    StLat: begin
                        if (ck_edge) begin
                            if (lat_cnt_q == LAT_W'(LATENCY_EDGES - 1)) begin
                                if (rw_q) begin
                                    state_q     <= StRdata;
                                    dq_oe_l_q   <= 1'b0;
                                    rwds_oe_l_q <= 1'b0;
                                    rwds_out_q  <= 1'b0;
                                    dq_out_q    <= '0;
                                end else begin
                                    state_q <= StWdata;
                                end
                            end else begin
                                lat_cnt_q <= lat_cnt_q + 1'b1;
                            end
                        end
                    end
                    StWdata: begin
                        if (ck_edge) odd_q <= !odd_q;
                    end
                    StRdata: begin
                        if (ck_edge) begin
                            dq_out_q   <= odd_q ? rd_word[7:0] : rd_word[15:8];
                            rwds_out_q <= !odd_q;
                            odd_q      <= !odd_q;
                        end
                    end
                    StRegw: begin
                        if (ck_edge) begin
                            if (!odd_q) begin
                                reg_hi_q <= bus.dram_dq_in;
                                odd_q    <= 1'b1;
                            end else begin
                                cr0_q   <= {reg_hi_q, bus.dram_dq_in};
                                state_q <= StIdle;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.dram_dq_out    = dq_out_q;
    assign bus.dram_dq_oe_l   = dq_oe_l_q;
    assign bus.dram_rwds_out  = rwds_out_q;
    assign bus.dram_rwds_oe_l = rwds_oe_l_q;
    assign cr0                = cr0_q;

endmodule

// File: tb/tb_hyperbus_responder.sv
// Bench for hyperbus_responder: drives HyperBus transactions as the
// controller and checks read bytes against a scoreboard of expected bytes.
module tb_hyperbus_responder;

    localparam int unsigned LAT = 22;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cr0;

    hyperbus_if hb();

    hyperbus_responder #(
        .MEM_AW        (10),
        .LATENCY_EDGES (LAT),
        .ID0_VAL       (16'h0C81),
        .CR0_RST       (16'h8F1F)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hb),
        .cr0   (cr0)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [8:0]  exp_q [$];    // {rwds, byte}
    logic [15:0] wr_data [8];
    logic [1:0]  wr_mask [8];  // [1] high byte, [0] low byte
    logic [47:0] ca_tmp;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CK edge, optionally preceded by idle clk cycles
    task automatic ck_step(input int gap);
        repeat (gap) tick();
        hb.dram_ck = ~hb.dram_ck;
        tick();
    endtask

    task automatic push_word(input logic [15:0] w);
        exp_q.push_back({1'b1, w[15:8]});
        exp_q.push_back({1'b0, w[7:0]});
    endtask

    task automatic pop_check();
        logic [8:0] e;
        if (exp_q.size() == 0) begin
            check_eq("sb_underflow", exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            check_eq("rd_byte", hb.dram_dq_out, e[7:0]);
            check_eq("rd_rwds", hb.dram_rwds_out, e[8]);
            check_eq("rd_dq_oe_l", hb.dram_dq_oe_l, 0);
        end
    endtask

    // Full transaction; stop_after >= 0 leaves CS low after that many data beats
    task automatic hb_xfer(input bit rd, input bit rs, input logic [31:0] addr,
                           input int nwords, input int gap, input int stop_after);
        logic [47:0] ca;
        ca = {rd, rs, 1'b1, addr[31:3], 13'd0, addr[2:0]};
        hb.dram_dq_in = '0;
        hb.dram_cs_l  = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            hb.dram_dq_in = ca[47 - 8*i -: 8];
            ck_step(gap);
            if (i == 0) begin
                check_eq("ca_rwds_oe_l", hb.dram_rwds_oe_l, 0);
                check_eq("ca_rwds_out", hb.dram_rwds_out, 1);
            end
        end
        if (rs && !rd) begin
            hb.dram_dq_in = wr_data[0][15:8];
            ck_step(gap);
            hb.dram_dq_in = wr_data[0][7:0];
            ck_step(gap);
            check_eq("cr0_regw", cr0, wr_data[0]);
        end else begin
            hb.dram_dq_in = '0;
            for (int i = 0; i < int'(LAT); i++) ck_step(gap);
            for (int w = 0; w < nwords; w++) begin
                for (int b = 0; b < 2; b++) begin
                    if (stop_after >= 0 && 2*w + b == stop_after) return;
                    if (rd) begin
                        ck_step(gap);
                        pop_check();
                    end else begin
                        hb.dram_dq_in   = (b == 0) ? wr_data[w][15:8] : wr_data[w][7:0];
                        hb.dram_rwds_in = (b == 0) ? wr_mask[w][1] : wr_mask[w][0];
                        ck_step(gap);
                    end
                end
            end
        end
        hb.dram_rwds_in = 1'b0;
        hb.dram_cs_l    = 1'b1;
        tick();
        tick();
        check_eq("end_dq_oe_l", hb.dram_dq_oe_l, 1);
        check_eq("end_rwds_oe_l", hb.dram_rwds_oe_l, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        hb.dram_ck      = 1'b0;
        hb.dram_cs_l    = 1'b1;
        hb.dram_rst_l   = 1'b1;
        hb.dram_dq_in   = '0;
        hb.dram_rwds_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_data[i] = '0;
            wr_mask[i] = 2'b00;
        end
        repeat (3) tick();
        check_eq("rst_dq_out", hb.dram_dq_out, 0);
        check_eq("rst_dq_oe_l", hb.dram_dq_oe_l, 1);
        check_eq("rst_rwds_out", hb.dram_rwds_out, 0);
        check_eq("rst_rwds_oe_l", hb.dram_rwds_oe_l, 1);
        check_eq("rst_cr0", cr0, 16'h8F1F);
        reset = 1'b0;
        tick();

        // Write then read two words at 0x010, read at full CK rate
        wr_data[0] = 16'h1234;
        wr_data[1] = 16'h5678;
        hb_xfer(1'b0, 1'b0, 32'h10, 2, 1, -1);
        push_word(16'h1234);
        push_word(16'h5678);
        hb_xfer(1'b1, 1'b0, 32'h10, 2, 0, -1);

        // Masked low byte over a cleared word
        wr_data[0] = 16'h0000;
        hb_xfer(1'b0, 1'b0, 32'h20, 1, 0, -1);
        wr_data[0] = 16'hAABB;
        wr_mask[0] = 2'b01;
        hb_xfer(1'b0, 1'b0, 32'h20, 1, 1, -1);
        wr_mask[0] = 2'b00;
        push_word(16'hAA00);
        hb_xfer(1'b1, 1'b0, 32'h20, 1, 1, -1);

        // Register write, then ID0 and CR0 reads
        wr_data[0] = 16'h8F17;
        hb_xfer(1'b0, 1'b1, 32'h0, 1, 1, -1);
        check_eq("cr0_after_regw", cr0, 16'h8F17);
        push_word(16'h0C81);
        hb_xfer(1'b1, 1'b1, 32'h0, 1, 1, -1);
        push_word(16'h8F17);
        hb_xfer(1'b1, 1'b1, 32'h1, 1, 0, -1);

        // Device reset restores CR0
        hb.dram_rst_l = 1'b0;
        tick();
        hb.dram_rst_l = 1'b1;
        tick();
        check_eq("cr0_dram_rst", cr0, 16'h8F1F);

        // Address wrap from the top word
        wr_data[0] = 16'h1111;
        wr_data[1] = 16'h2222;
        wr_data[2] = 16'h3333;
        hb_xfer(1'b0, 1'b0, 32'h3FF, 3, 0, -1);
        push_word(16'h2222);
        hb_xfer(1'b1, 1'b0, 32'h000, 1, 1, -1);
        push_word(16'h3333);
        hb_xfer(1'b1, 1'b0, 32'h001, 1, 1, -1);
        push_word(16'h1111);
        push_word(16'h2222);
        push_word(16'h3333);
        hb_xfer(1'b1, 1'b0, 32'h3FF, 3, 0, -1);

        // Abort after three CA bytes, then a full transaction
        ca_tmp = {1'b1, 1'b0, 1'b1, 29'h4, 13'd0, 3'd0};
        hb.dram_cs_l = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            hb.dram_dq_in = ca_tmp[47 - 8*i -: 8];
            ck_step(1);
        end
        check_eq("abort_pre_rwds_oe_l", hb.dram_rwds_oe_l, 0);
        hb.dram_cs_l = 1'b1;
        tick();
        check_eq("abort_rwds_oe_l", hb.dram_rwds_oe_l, 1);
        check_eq("abort_dq_oe_l", hb.dram_dq_oe_l, 1);
        push_word(16'h5678);
        hb_xfer(1'b1, 1'b0, 32'h11, 1, 1, -1);

        // Asynchronous reset in the middle of a read burst
        push_word(16'h1234);
        push_word(16'h5678);
        hb_xfer(1'b1, 1'b0, 32'h10, 2, 1, 2);
        check_eq("mid_rd_dq_oe_l", hb.dram_dq_oe_l, 0);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_dq_out", hb.dram_dq_out, 0);
        check_eq("arst_dq_oe_l", hb.dram_dq_oe_l, 1);
        check_eq("arst_rwds_out", hb.dram_rwds_out, 0);
        check_eq("arst_rwds_oe_l", hb.dram_rwds_oe_l, 1);
        hb.dram_cs_l = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        exp_q.delete();
        push_word(16'h1234);
        push_word(16'h5678);
        hb_xfer(1'b1, 1'b0, 32'h10, 2, 0, -1);

        check_eq("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
